// File: rtl/rsa_seq_pkg.sv
// rsa_seq_pkg: shared state type and stop-merge constants for the rsa sequencer
package rsa_seq_pkg;
    typedef enum logic [2:0] {RESET, IDLE, EN, WAIT_EOC, EOC, TIMEOUT} rsa_seq_state_t;
    localparam int STOP_AND = 0;
    localparam int STOP_OR  = 1;
endpackage

// File: rtl/rsa_seq_chan.sv
// rsa_seq_chan: one rsa_unit channel - enable, delayed reset release, eoc wait and watchdog
module rsa_seq_chan
    import rsa_seq_pkg::*;
#(
    parameter int RST_DLY = 1,
    parameter int TMO_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic             unit_eoc,
    input  logic [TMO_W-1:0] timeout_cycles,
    output logic             en_rsa,
    output logic             rst_rsa,
    output logic             eoc,
    output logic             err,
    output logic             busy
);
    localparam int DW = $clog2(RST_DLY + 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(RST_DLY - 1);

    rsa_seq_state_t   state, state_d;
    logic [DW-1:0]    dly_cnt, dly_d;
    logic [TMO_W-1:0] wd_cnt, wd_d;
    logic             err_d;

    // next-state and counter updates; the watchdog counter saturates when the limit is 0
    always_comb begin
        state_d = state;
        dly_d   = dly_cnt;
        wd_d    = wd_cnt;
        err_d   = err;
        case (state)
            RESET: state_d = IDLE;
            IDLE: if (start) begin
                state_d = EN;
                dly_d   = '0;
                err_d   = 1'b0;
            end
            EN: if (stop) state_d = IDLE;
                else if (dly_cnt == DLY_LAST) begin
                    state_d = WAIT_EOC;
                    wd_d    = '0;
                end else dly_d = dly_cnt + DW'(1);
            WAIT_EOC: if (stop) state_d = IDLE;
                else if (unit_eoc) state_d = EOC;
                else if (timeout_cycles != '0 && wd_cnt == timeout_cycles - TMO_W'(1)) state_d = TIMEOUT;
                else wd_d = (&wd_cnt) ? wd_cnt : wd_cnt + TMO_W'(1);
            EOC: state_d = IDLE;
            TIMEOUT: begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
            default: state_d = RESET;
        endcase
    end

    // state and counters advance only on enabled edges; reset is asynchronous
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET;
            dly_cnt <= '0;
            wd_cnt  <= '0;
            err     <= 1'b0;
        end else if (ena) begin
            state   <= state_d;
            dly_cnt <= dly_d;
            wd_cnt  <= wd_d;
            err     <= err_d;
        end
    end

    assign en_rsa  = state inside {EN, WAIT_EOC, EOC};
    assign rst_rsa = state inside {WAIT_EOC, EOC};
    assign eoc     = state == EOC;
    assign busy    = state inside {EN, WAIT_EOC};
endmodule

// File: rtl/rsa_seq_ctrl.sv
// rsa_seq_ctrl: NUM_CH independent rsa_unit sequencers with a shared interrupt
module rsa_seq_ctrl
    import rsa_seq_pkg::*;
#(
    parameter int NUM_CH    = 1,
    parameter int RST_DLY   = 1,
    parameter int TMO_W     = 16,
    parameter int STOP_MODE = STOP_AND
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NUM_CH-1:0] gpio_start,
    input  logic [NUM_CH-1:0] spi_start,
    input  logic [NUM_CH-1:0] gpio_stop,
    input  logic [NUM_CH-1:0] spi_stop,
    input  logic [TMO_W-1:0]  timeout_cycles,
    input  logic [NUM_CH-1:0] eoc_rsa_unit,
    output logic [NUM_CH-1:0] en_rsa,
    output logic [NUM_CH-1:0] rst_rsa,
    output logic [NUM_CH-1:0] eoc,
    output logic [NUM_CH-1:0] err,
    output logic [NUM_CH-1:0] busy,
    output logic              irq
);
    logic [NUM_CH-1:0] err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rsa_seq_chan #(.RST_DLY(RST_DLY), .TMO_W(TMO_W)) u_chan (
            .clk            (clk),
            .rst            (rst),
            .ena            (ena),
            .start          (gpio_start[g] | spi_start[g]),
            .stop           (STOP_MODE == STOP_OR ? (gpio_stop[g] | spi_stop[g]) : (gpio_stop[g] & spi_stop[g])),
            .unit_eoc       (eoc_rsa_unit[g]),
            .timeout_cycles (timeout_cycles),
            .en_rsa         (en_rsa[g]),
            .rst_rsa        (rst_rsa[g]),
            .eoc            (eoc[g]),
            .err            (err[g]),
            .busy           (busy[g])
        );
    end

    // delayed err copy every clock so a new timeout raises irq for a single cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= '0;
        else err_q <= err;
    end

    assign irq = (|eoc) | (|(err & ~err_q));
endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// tb_rsa_seq_ctrl: directed and random checks of two sequencer configurations against a phase model
module tb_rsa_seq_ctrl;
    localparam int P_RST = 0, P_IDLE = 1, P_EN = 2, P_WAIT = 3, P_EOC = 4, P_TMO = 5;

    logic clk = 0, rst = 1, ena = 0;
    logic [5:0] gs = '0, ss = '0, gp = '0, sp = '0, ue = '0;
    logic [15:0] tmo0 = '0, tmo1 = '0;
    logic [3:0] en_a, rr_a, eoc_a, err_a, busy_a;
    logic [1:0] en_b, rr_b, eoc_b, err_b, busy_b;
    logic irq0, irq1;
    wire [5:0] en_o = {en_b, en_a};
    wire [5:0] rr_o = {rr_b, rr_a};
    wire [5:0] eoc_o = {eoc_b, eoc_a};
    wire [5:0] err_o = {err_b, err_a};
    wire [5:0] busy_o = {busy_b, busy_a};

    int total = 0, bad = 0;
    int md[6], ph_start[6], tk = 0;
    bit merr[6], merr_q[6];
    bit chk_on = 0;

    always #5 clk = ~clk;

    rsa_seq_ctrl #(.NUM_CH(4), .RST_DLY(4), .TMO_W(16), .STOP_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .ena(ena),
        .gpio_start(gs[3:0]), .spi_start(ss[3:0]), .gpio_stop(gp[3:0]), .spi_stop(sp[3:0]),
        .timeout_cycles(tmo0), .eoc_rsa_unit(ue[3:0]),
        .en_rsa(en_a), .rst_rsa(rr_a), .eoc(eoc_a), .err(err_a), .busy(busy_a), .irq(irq0)
    );

    rsa_seq_ctrl #(.NUM_CH(2), .RST_DLY(1), .TMO_W(16), .STOP_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena),
        .gpio_start(gs[5:4]), .spi_start(ss[5:4]), .gpio_stop(gp[5:4]), .spi_stop(sp[5:4]),
        .timeout_cycles(tmo1), .eoc_rsa_unit(ue[5:4]),
        .en_rsa(en_b), .rst_rsa(rr_b), .eoc(eoc_b), .err(err_b), .busy(busy_b), .irq(irq1)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // Reference: each channel is in a named phase; phase length is measured in enabled edges
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 6; c++) begin
                md[c] = P_RST;
                merr[c] = 0;
                merr_q[c] = 0;
                ph_start[c] = 0;
            end
        end else begin
            for (int c = 0; c < 6; c++) merr_q[c] = merr[c];
            if (ena) begin
                for (int c = 0; c < 6; c++) begin
                    bit st, sto;
                    int dl, t;
                    st  = gs[c] | ss[c];
                    sto = (c >= 4) ? (gp[c] | sp[c]) : (gp[c] & sp[c]);
                    dl  = (c >= 4) ? 1 : 4;
                    t   = (c >= 4) ? int'(tmo1) : int'(tmo0);
                    if (md[c] == P_RST) md[c] = P_IDLE;
                    else if (md[c] == P_IDLE) begin
                        if (st) begin md[c] = P_EN; ph_start[c] = tk; merr[c] = 0; end
                    end else if (md[c] == P_EN) begin
                        if (sto) md[c] = P_IDLE;
                        else if (tk - ph_start[c] == dl) begin md[c] = P_WAIT; ph_start[c] = tk; end
                    end else if (md[c] == P_WAIT) begin
                        if (sto) md[c] = P_IDLE;
                        else if (ue[c]) md[c] = P_EOC;
                        else if (t != 0 && tk - ph_start[c] == t) md[c] = P_TMO;
                    end else if (md[c] == P_EOC) md[c] = P_IDLE;
                    else begin md[c] = P_IDLE; merr[c] = 1; end
                end
                tk++;
            end
        end
    end

    function automatic logic [5:0] mvec(input int which);
        logic [5:0] v = '0;
        for (int c = 0; c < 6; c++)
            case (which)
                0: v[c] = md[c] inside {P_EN, P_WAIT, P_EOC};
                1: v[c] = md[c] inside {P_WAIT, P_EOC};
                2: v[c] = md[c] == P_EOC;
                3: v[c] = merr[c];
                4: v[c] = md[c] inside {P_EN, P_WAIT};
                default: v[c] = merr[c] & ~merr_q[c];
            endcase
        return v;
    endfunction

    // Every cycle, just after the edge, compare both instances against the model
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            logic [5:0] e, r;
            e = mvec(2);
            r = mvec(5);
            chk("m_en", en_o, mvec(0));
            chk("m_rst_rsa", rr_o, mvec(1));
            chk("m_eoc", eoc_o, e);
            chk("m_err", err_o, mvec(3));
            chk("m_busy", busy_o, mvec(4));
            chk("m_irq0", irq0, (|e[3:0]) | (|r[3:0]));
            chk("m_irq1", irq1, (|e[5:4]) | (|r[5:4]));
        end
    end

    initial begin
        rst = 1; ena = 1; tmo0 = 8; tmo1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_en", en_o, 0);
        chk("rst_rr", rr_o, 0);
        chk("rst_eoc", eoc_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_irq", {irq1, irq0}, 0);
        rst = 0;
        chk_on = 1;
        repeat (2) @(negedge clk);

        // single-cycle release delay, unit eoc after 10 cycles
        gs[4] = 1; @(negedge clk); gs[4] = 0;
        chk("t1_en", en_o[4], 1);
        chk("t1_rr0", rr_o[4], 0);
        @(negedge clk);
        chk("t1_rr1", rr_o[4], 1);
        repeat (8) @(negedge clk);
        ue[4] = 1; @(negedge clk); ue[4] = 0;
        chk("t1_eoc", eoc_o[4], 1);
        chk("t1_irq", irq1, 1);
        @(negedge clk);
        chk("t1_eoc_off", eoc_o[4], 0);
        chk("t1_idle", en_o[4], 0);

        // four-cycle release delay, unit eoc ignored in EN, then 8-cycle watchdog
        ss[1] = 1; @(negedge clk); ss[1] = 0; ue[1] = 1;
        chk("t2_en", en_o[1], 1);
        chk("t2_rr", rr_o[1], 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("t2_rr_hold", rr_o[1], 0);
        end
        ue[1] = 0;
        @(negedge clk);
        chk("t2_rr_up", rr_o[1], 1);
        chk("t2_no_eoc", eoc_o[1], 0);
        repeat (7) @(negedge clk);
        chk("t3_still_en", en_o[1], 1);
        @(negedge clk);
        chk("t3_en_drop", en_o[1], 0);
        chk("t3_err_pre", err_o[1], 0);
        @(negedge clk);
        chk("t3_err", err_o[1], 1);
        chk("t3_irq", irq0, 1);
        @(negedge clk);
        chk("t3_irq_once", irq0, 0);
        chk("t3_err_sticky", err_o[1], 1);
        gs[1] = 1; @(negedge clk); gs[1] = 0;
        chk("t3_err_clr", err_o[1], 0);

        // stop combining: AND on dut0, OR on dut1
        gs[0] = 1; gs[5] = 1; @(negedge clk); gs[0] = 0; gs[5] = 0;
        repeat (4) @(negedge clk);
        gp[0] = 1; gp[5] = 1; @(negedge clk); gp[0] = 0; gp[5] = 0;
        chk("t4_and_hold", en_o[0], 1);
        chk("t4_or_abort", en_o[5], 0);
        gp[0] = 1; sp[0] = 1; @(negedge clk); gp[0] = 0; sp[0] = 0;
        chk("t4_and_abort", en_o[0], 0);
        chk("t4_no_eoc", eoc_o[0], 0);

        // simultaneous eoc on ch0 and ch3
        repeat (3) @(negedge clk);
        gs[0] = 1; ss[3] = 1; @(negedge clk); gs[0] = 0; ss[3] = 0;
        repeat (4) @(negedge clk);
        ue[0] = 1; ue[3] = 1; @(negedge clk); ue[0] = 0; ue[3] = 0;
        chk("t5_eoc_pair", eoc_a, 4'b1001);
        chk("t5_irq", irq0, 1);

        // ena freeze in WAIT_EOC then asynchronous reset
        repeat (3) @(negedge clk);
        gs[2] = 1; @(negedge clk); gs[2] = 0;
        repeat (5) @(negedge clk);
        ena = 0;
        repeat (5) @(negedge clk);
        chk("t6_frozen_en", en_o[2], 1);
        chk("t6_frozen_rr", rr_o[2], 1);
        ena = 1;
        repeat (4) @(negedge clk);
        chk("t6_wd_held", en_o[2], 1);
        @(posedge clk); #3 rst = 1; #1;
        chk("t6_async_en", en_o, 0);
        chk("t6_async_rr", rr_o, 0);
        @(negedge clk); rst = 0;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n % 200 == 0) begin
                int opts[4] = '{0, 3, 8, 20};
                tmo0 = 16'(opts[$urandom_range(3)]);
                tmo1 = 16'(opts[$urandom_range(3)]);
            end
            ena = ($urandom_range(9) != 0);
            for (int c = 0; c < 6; c++) begin
                gs[c] = ($urandom_range(7) == 0);
                ss[c] = ($urandom_range(15) == 0);
                gp[c] = ($urandom_range(5) == 0);
                sp[c] = ($urandom_range(5) == 0);
                ue[c] = ($urandom_range(9) == 0);
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
